// File: rtl/transmissor_display_spi.sv
// transmissor_display_spi
//   Streams one 128x64 monochrome frame to an SSD1306-class panel over 4-wire
//   SPI (mode 0, MSB first). Every frame begins with a six-byte addressing
//   header (dc=0), which is followed by N_BYTES data bytes (dc=1) taken from
//   a snapshot of `imagem`. That snapshot is captured when the frame starts.
//
// Ports
//   clk, rst_n     system clock (rising edge), async active-low reset
//   iniciar        start request; honoured only while idle
//   imagem         frame bus, byte i = imagem[i*8 +: 8]
//   ocupado        frame in flight
//   quadro_pronto  one-cycle pulse on the cycle the last sclk falls
//   sclk/mosi/cs_n/dc  SPI pins, sclk idles low
module transmissor_display_spi #(
  parameter int DIV_SCLK = 4,
  parameter int N_BYTES  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iniciar,
  input  logic [N_BYTES*8-1:0] imagem,
  output logic                 ocupado,
  output logic                 quadro_pronto,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs_n,
  output logic                 dc
);

  localparam int DIV_W  = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam int BYTE_W = $clog2(N_BYTES + 6);
  localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_SCLK - 1);
  localparam logic [BYTE_W-1:0] HDR_LAST  = BYTE_W'(5);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES + 5);

  // Addressing header: column 0..127, page 0..7. HDR[0] is sent first.
  localparam logic [5:0][7:0] HDR = {8'h07, 8'h00, 8'h22, 8'h7F, 8'h00, 8'h21};

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ENVIA_CMD  = 2'd1,
    ENVIA_DADO = 2'd2
  } estado_t;

  estado_t estado, estado_nxt;

  logic [DIV_W-1:0]         div_cnt;
  logic [2:0]               bit_cnt;   // 0 = MSB of the current byte
  logic [BYTE_W-1:0]        byte_cnt;  // 0..5 header, 6.. data
  logic                     sclk_q;
  logic                     pronto_q;
  logic [N_BYTES-1:0][7:0]  snap;

  logic                     inicio;
  logic                     meio_fim;
  logic                     bit_fim;
  logic                     byte_fim;
  logic                     ultimo;
  logic [IDX_W-1:0]         data_idx;
  logic [7:0]               byte_atual;

  // Timing strobes. A bit is two half-periods: a low half and a high half.
  // The bit ends on the last cycle of the high half, and the edge at the end
  // of that cycle drops sclk and presents the next bit on mosi.
  always_comb begin
    inicio   = (estado == OCIOSO) && iniciar;
    meio_fim = (div_cnt == DIV_LAST);
    bit_fim  = meio_fim && sclk_q;
    byte_fim = bit_fim && (bit_cnt == 3'd7);
    ultimo   = byte_fim && (byte_cnt == BYTE_LAST) && (estado == ENVIA_DADO);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_nxt;
  end

  // Next-state logic
  always_comb begin
    estado_nxt = estado;
    case (estado)
      OCIOSO:     if (inicio) estado_nxt = ENVIA_CMD;
      ENVIA_CMD:  if (byte_fim && (byte_cnt == HDR_LAST)) estado_nxt = ENVIA_DADO;
      ENVIA_DADO: if (ultimo) estado_nxt = OCIOSO;
      default:    estado_nxt = OCIOSO;
    endcase
  end

  // Divider / bit / byte counters. These are held clear while idle, so a new
  // frame starts from zero on the edge that accepts iniciar. The byte counter
  // stops on the final byte rather than stepping past N_BYTES+5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sclk_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= ultimo;
      if (estado == OCIOSO) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sclk_q   <= 1'b0;
      end else if (meio_fim) begin
        div_cnt <= '0;
        sclk_q  <= ~sclk_q;
        if (sclk_q) begin
          bit_cnt <= byte_fim ? 3'd0 : bit_cnt + 3'd1;
          if (byte_fim && !ultimo) byte_cnt <= byte_cnt + BYTE_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // The frame snapshot has no reset because it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (inicio) snap <= imagem;
  end

  // Byte selection. data_idx is only meaningful in ENVIA_DADO.
  always_comb begin
    data_idx   = IDX_W'(byte_cnt - BYTE_W'(6));
    byte_atual = (estado == ENVIA_CMD) ? HDR[byte_cnt[2:0]] : snap[data_idx];
  end

  // Outputs
  always_comb begin
    ocupado       = (estado != OCIOSO);
    cs_n          = ~ocupado;
    dc            = (estado == ENVIA_DADO);
    sclk          = sclk_q;
    quadro_pronto = pronto_q;
    mosi          = ocupado ? byte_atual[~bit_cnt] : 1'b0;
  end

endmodule

// File: doc/transmissor_display_spi.md
Name: transmissor_display_spi

Overview:
- Consumes the 1024-byte monochrome frame bus produced by the image controller (128x64, 8 vertical pixels per byte).
- Serialises the frame to an SSD1306-class display over 4-wire SPI: mode 0, MSB first, with a D/C line.
- Each frame is preceded by a fixed addressing command header.
- Sits between the image controller and the top-level display pins. It is the reader/transmitter end of the `imagem` bus.

Parameters:
- DIV_SCLK, 4, system clocks per SCLK half-period. Legal values are 1 or greater.
- N_BYTES, 1024, data bytes per frame. The `imagem` width is N_BYTES*8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iniciar  input  1  start-frame request, sampled on clk.
- imagem  input  N_BYTES*8  frame; byte i = imagem[i*8 +: 8].
- ocupado  output  1  high while a frame is in flight.
- quadro_pronto  output  1  one-cycle pulse at end of frame.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  SPI data.
- cs_n  output  1  chip select, active low.
- dc  output  1  0 = command byte, 1 = data byte.

Behaviour:
- Reset (async, rst_n=0):
  - sclk=0, mosi=0, cs_n=1, dc=0, ocupado=0, quadro_pronto=0.
  - FSM goes to OCIOSO; all counters clear.
  - Asserting reset mid-frame aborts immediately; no partial completion pulse is generated.
- States: OCIOSO -> ENVIA_CMD -> ENVIA_DADO -> OCIOSO.
- Start:
  - In OCIOSO, iniciar=1 at edge T has the following effect from T+1:
    - imagem is latched into an internal snapshot.
    - ocupado=1, cs_n=0, dc=0.
    - mosi = MSB of command byte 0.
  - The snapshot is the only source for the whole frame; changes on imagem during the frame have no effect.
- Command header (dc=0): six bytes, in order 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07 (column 0..127, page 0..7).
- Data phase (dc=1): snapshot bytes 0..N_BYTES-1, in index order.
- Bit timing:
  - Each bit lasts 2*DIV_SCLK cycles.
  - mosi is updated at bit start while sclk is low.
  - sclk rises DIV_SCLK cycles after bit start and falls at the next bit start.
  - Bits are sent MSB first (bit 7 .. bit 0).
- Byte boundaries:
  - Bytes are contiguous; there are no gap cycles.
  - dc changes only together with the first bit of the first data byte.
- Frame length:
  - Frame length is (6+N_BYTES)*16*DIV_SCLK cycles from T+1 to the end cycle E.
  - For the defaults this is 65920 cycles.
- End cycle E (last sclk falling edge):
  - sclk=0, cs_n=1, ocupado=0, quadro_pronto=1 for exactly one cycle.
  - dc=0, mosi=0.
  - FSM returns to OCIOSO.
- iniciar handling:
  - iniciar while ocupado=1 is ignored; it is not queued.
  - iniciar=1 during cycle E is accepted. The next frame then starts at E+1 with cs_n=0, so cs_n is high for exactly one cycle.
  - iniciar held continuously produces back-to-back frames with a one-cycle cs_n-high gap.
- Counters:
  - Divider counter: ceil(log2(DIV_SCLK)) bits, minimum 1.
  - Bit counter: 3 bits.
  - Byte counter: ceil(log2(N_BYTES+6)) bits.
  - No counter wraps during a frame.

Test Plan:
- Reset: hold rst_n=0, then release -> sclk=0, cs_n=1, dc=0, ocupado=0, quadro_pronto=0; no sclk edges while iniciar=0.
- Header check, DIV_SCLK=2, single iniciar pulse -> SPI monitor (sample mosi on sclk rise) decodes 0x21,0x00,0x7F,0x22,0x00,0x07 with dc=0; first sclk rise 2 cycles after cs_n falls.
- Data ordering, imagem byte i = i[7:0] -> 1024 bytes 0x00,0x01,...,0xFF repeating with dc=1; quadro_pronto pulses once, exactly 1030*32 cycles after cs_n falls.
- Snapshot and ignore:
  - Change imagem to all 0xAA right after start -> all data bytes still match the original pattern.
  - Pulse iniciar mid-frame -> no extra frame.
- Back-to-back: iniciar held high -> two frames; cs_n high exactly one cycle between them; quadro_pronto pulses twice.
- Reset mid-frame: assert rst_n=0 during data byte 500 -> outputs return to reset values immediately; no quadro_pronto. A new iniciar then sends a complete frame starting with 0x21.
